// File: rtl/nf10_axis_port_tx_filter_pkg.sv
// Shared definitions for the egress port filter: tuser field layout, FSM states, byte helpers.
package nf10_tx_filter_pkg;

    // NetFPGA metadata layout inside tuser (valid on the first beat only)
    localparam int unsigned LEN_LO = 0;
    localparam int unsigned LEN_HI = 15;
    localparam int unsigned SRC_LO = 16;
    localparam int unsigned SRC_HI = 23;
    localparam int unsigned DST_LO = 24;
    localparam int unsigned DST_HI = 31;

    // Widest tstrb the popcount helper accepts; narrower strobes are zero-extended
    localparam int unsigned MAX_STRB_WIDTH = 64;

    typedef enum logic [1:0] {
        StHdr,
        StFwd,
        StDrop
    } tx_state_e;

    function automatic logic [15:0] popcount(input logic [MAX_STRB_WIDTH-1:0] v);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            cnt = cnt + 16'(v[i]);
        end
        return cnt;
    endfunction

    // 16-bit add that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/nf10_axis_port_tx_filter_if.sv
// AXI-Stream bundle with NetFPGA tuser metadata; master drives payload, slave drives tready.
interface nf10_axis_port_tx_filter_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned USER_WIDTH = 128
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [STRB_WIDTH-1:0] tstrb;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast,
                    input tready);
    modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast,
                    output tready);
endinterface

// File: rtl/nf10_axis_skid_buffer.sv
// Two-entry register slice: output register plus one skid slot, with a registered in_ready_o.
module nf10_axis_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned STRB_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [STRB_WIDTH-1:0] in_strb_i,
    input  logic [USER_WIDTH-1:0] in_user_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [STRB_WIDTH-1:0] out_strb_o,
    output logic [USER_WIDTH-1:0] out_user_o,
    output logic                  out_last_o
);
    localparam int unsigned PW = DATA_WIDTH + STRB_WIDTH + USER_WIDTH + 1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] out_pl_q, out_pl_d, skid_pl_q, skid_pl_d;
    logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic          ready_q, ready_d;
    logic          in_fire, out_free;

    assign in_pl = {in_data_i, in_strb_i, in_user_i, in_last_i};

    // Load the output slot from skid first, else from input; park input in skid when stalled.
    // ready tracks "skid empty" one cycle late, so in_fire never coincides with a full skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pl_d     = out_pl_q;
        skid_valid_d = skid_valid_q;
        skid_pl_d    = skid_pl_q;
        in_fire      = in_valid_i & ready_q;
        out_free     = ~out_valid_q | out_ready_i;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pl_d     = skid_pl_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_pl_d = in_pl;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_pl_d    = in_pl;
        end
        ready_d = ~skid_valid_d;
    end

    // Slice state; ready is held low throughout reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_pl_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pl_q    <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pl_q     <= out_pl_d;
            skid_valid_q <= skid_valid_d;
            skid_pl_q    <= skid_pl_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign {out_data_o, out_strb_o, out_user_o, out_last_o} = out_pl_q;

endmodule

// File: rtl/nf10_axis_port_tx_filter.sv
// Egress packet gate: forwards packets whose dst_port hits C_PORT_MASK, drops the rest,
// and checks declared length against delivered bytes on forwarded packets.
module nf10_axis_port_tx_filter
    import nf10_tx_filter_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_PORT_MASK          = 8'h01
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    nf10_axis_port_tx_filter_if.slave         s_axis,
    nf10_axis_port_tx_filter_if.master        m_axis,
    output logic [31:0]                       fwd_count,
    output logic [31:0]                       drop_count,
    output logic [15:0]                       len_err_count,
    output logic                              len_err
);
    localparam int unsigned STRB_WIDTH = C_S_AXIS_DATA_WIDTH / 8;

    tx_state_e   state_q, state_d;
    logic [15:0] len_q, len_d, acc_q, acc_d, len_err_count_q, len_err_count_d;
    logic [31:0] fwd_count_q, fwd_count_d, drop_count_q, drop_count_d;
    logic        len_err_q, len_err_d;
    logic        buf_ready, hit, pass, accept, fwd_beat, fwd_end, drop_end;
    logic [15:0] beat_bytes, byte_sum, pkt_len;

    assign hit = |(s_axis.tuser[DST_HI:DST_LO] & C_PORT_MASK);
    // Whether the current beat goes to the buffer; tuser only matters on the header beat
    assign pass = (state_q == StFwd) | ((state_q == StHdr) & hit);
    // tready depends on state and buffer only, never on tuser
    assign s_axis.tready = (state_q == StDrop) | buf_ready;
    assign accept   = s_axis.tvalid & s_axis.tready;
    assign fwd_beat = accept & pass;
    assign fwd_end  = fwd_beat & s_axis.tlast;
    assign drop_end = accept & ~pass & s_axis.tlast;

    assign beat_bytes = popcount(MAX_STRB_WIDTH'(s_axis.tstrb));
    assign byte_sum   = sat_add16(acc_q, beat_bytes);
    assign pkt_len    = (state_q == StHdr) ? s_axis.tuser[LEN_HI:LEN_LO] : len_q;

    nf10_axis_skid_buffer #(
        .DATA_WIDTH (C_S_AXIS_DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .USER_WIDTH (C_S_AXIS_TUSER_WIDTH)
    ) u_skid (
        .clk_i       (axi_aclk),
        .rst_ni      (axi_resetn),
        .in_valid_i  (s_axis.tvalid & pass),
        .in_ready_o  (buf_ready),
        .in_data_i   (s_axis.tdata),
        .in_strb_i   (s_axis.tstrb),
        .in_user_i   (s_axis.tuser),
        .in_last_i   (s_axis.tlast),
        .out_valid_o (m_axis.tvalid),
        .out_ready_i (m_axis.tready),
        .out_data_o  (m_axis.tdata),
        .out_strb_o  (m_axis.tstrb),
        .out_user_o  (m_axis.tuser),
        .out_last_o  (m_axis.tlast)
    );

    // Next-state: packet FSM, length capture, byte accumulator and saturating counters
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        acc_d           = acc_q;
        len_err_d       = 1'b0;
        fwd_count_d     = fwd_count_q;
        drop_count_d    = drop_count_q;
        len_err_count_d = len_err_count_q;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    len_d = s_axis.tuser[LEN_HI:LEN_LO];
                    if (!s_axis.tlast) state_d = hit ? StFwd : StDrop;
                end
            end
            StFwd, StDrop: begin
                if (accept && s_axis.tlast) state_d = StHdr;
            end
            default: state_d = StHdr;
        endcase

        if (fwd_beat) acc_d = s_axis.tlast ? 16'd0 : byte_sum;

        if (fwd_end && byte_sum != pkt_len) begin
            len_err_d = 1'b1;
            if (len_err_count_q != 16'hFFFF) len_err_count_d = len_err_count_q + 16'd1;
        end
        if (fwd_end && fwd_count_q != 32'hFFFF_FFFF) fwd_count_d = fwd_count_q + 32'd1;
        if (drop_end && drop_count_q != 32'hFFFF_FFFF) drop_count_d = drop_count_q + 32'd1;
    end

    // State and statistics registers
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q         <= StHdr;
            len_q           <= '0;
            acc_q           <= '0;
            len_err_q       <= 1'b0;
            fwd_count_q     <= '0;
            drop_count_q    <= '0;
            len_err_count_q <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            acc_q           <= acc_d;
            len_err_q       <= len_err_d;
            fwd_count_q     <= fwd_count_d;
            drop_count_q    <= drop_count_d;
            len_err_count_q <= len_err_count_d;
        end
    end

    assign fwd_count     = fwd_count_q;
    assign drop_count    = drop_count_q;
    assign len_err_count = len_err_count_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_nf10_axis_port_tx_filter.sv
// Directed bench for the egress port filter with hand-computed expectations.
module tb_nf10_axis_port_tx_filter;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] fwd_count, drop_count;
    logic [15:0] len_err_count;
    logic        len_err;

    int n_checks = 0;
    int n_errs   = 0;

    beat_t exp_q[$];
    beat_t act_q[$];
    int    m_valid_cycles = 0;
    int    len_err_pulses = 0;
    int    s_stall_cycles = 0;
    int    stall_viol     = 0;
    logic  stall_prev     = 1'b0;
    beat_t prev_beat;

    nf10_axis_port_tx_filter_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
    nf10_axis_port_tx_filter_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

    nf10_axis_port_tx_filter #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128),
        .C_PORT_MASK          (8'h01)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .fwd_count     (fwd_count),
        .drop_count    (drop_count),
        .len_err_count (len_err_count),
        .len_err       (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Observe the m side and upstream stalls half a cycle away from the active edge
    always @(negedge clk) begin
        beat_t cur;
        cur = '{d: m_if.tdata, s: m_if.tstrb, u: m_if.tuser, l: m_if.tlast};
        if (m_if.tvalid && m_if.tready) act_q.push_back(cur);
        if (stall_prev && (!m_if.tvalid || cur != prev_beat)) stall_viol <= stall_viol + 1;
        stall_prev <= m_if.tvalid && !m_if.tready;
        prev_beat  <= cur;
        if (m_if.tvalid) m_valid_cycles <= m_valid_cycles + 1;
        if (len_err) len_err_pulses <= len_err_pulses + 1;
        if (s_if.tvalid && !s_if.tready) s_stall_cycles <= s_stall_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_user(input logic [7:0] dst, input logic [15:0] len);
        return {96'h0, dst, 8'h5A, len};
    endfunction

    function automatic beat_t mk_beat(input logic [31:0] id, input logic [127:0] u,
                                      input logic l);
        return '{d: {8{32'hA500_0000 | id}}, s: 32'hFFFF_FFFF, u: u, l: l};
    endfunction

    // Present one beat from posedge+1 and return at posedge+1 after it is accepted
    task automatic send_beat(input beat_t b);
        int waited;
        s_if.tdata  = b.d;
        s_if.tstrb  = b.s;
        s_if.tuser  = b.u;
        s_if.tlast  = b.l;
        s_if.tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_if.tready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!s_if.tready) check_eq("send_timeout", 512'(waited), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check_eq({tag, "_count"}, 512'(act_q.size()), 512'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_beat%0d", tag, i), 512'(act_q[i]), 512'(exp_q[i]));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        beat_t b0, b1, b2, b3;
        int    base_valid, base_stall, base_lerr;

        rst_n        = 1'b0;
        s_if.tdata   = '0;
        s_if.tstrb   = '0;
        s_if.tuser   = '0;
        s_if.tlast   = 1'b0;
        s_if.tvalid  = 1'b0;
        m_if.tready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_eq("rst_m_tdata", 512'(m_if.tdata), 512'(0));
        check_eq("rst_m_tuser", 512'(m_if.tuser), 512'(0));
        check_eq("rst_s_tready", 512'(s_if.tready), 512'(0));
        check_eq("rst_fwd_count", 512'(fwd_count), 512'(0));
        check_eq("rst_drop_count", 512'(drop_count), 512'(0));
        check_eq("rst_len_err_count", 512'(len_err_count), 512'(0));
        check_eq("rst_len_err", 512'(len_err), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: two-beat hit, len 64, one-cycle latency
        base_lerr = len_err_pulses;
        b0 = mk_beat(32'h10, mk_user(8'h01, 16'd64), 1'b0);
        b1 = mk_beat(32'h11, 128'h0, 1'b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        send_beat(b0);
        check_eq("t1_latency_valid", 512'(m_if.tvalid), 512'(1));
        check_eq("t1_latency_data", 512'(m_if.tdata), 512'(b0.d));
        send_beat(b1);
        idle(4);
        compare_beats("t1");
        check_eq("t1_fwd_count", 512'(fwd_count), 512'(1));
        check_eq("t1_len_err_pulses", 512'(len_err_pulses - base_lerr), 512'(0));

        // 2: three-beat miss to dst 0x04, dropped without stalling
        base_valid = m_valid_cycles;
        base_stall = s_stall_cycles;
        send_beat(mk_beat(32'h20, mk_user(8'h04, 16'd96), 1'b0));
        send_beat(mk_beat(32'h21, 128'h0, 1'b0));
        send_beat(mk_beat(32'h22, 128'h0, 1'b1));
        idle(4);
        check_eq("t2_m_valid_cycles", 512'(m_valid_cycles - base_valid), 512'(0));
        check_eq("t2_s_stalls", 512'(s_stall_cycles - base_stall), 512'(0));
        check_eq("t2_drop_count", 512'(drop_count), 512'(1));
        check_eq("t2_m_beats", 512'(act_q.size()), 512'(0));
        act_q.delete();

        // 3: four-beat hit with downstream stalled three cycles mid-packet
        b0 = mk_beat(32'h30, mk_user(8'h03, 16'd128), 1'b0);
        b1 = mk_beat(32'h31, 128'h1, 1'b0);
        b2 = mk_beat(32'h32, 128'h2, 1'b0);
        b3 = mk_beat(32'h33, 128'h3, 1'b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        fork
            begin
                send_beat(b0);
                send_beat(b1);
                send_beat(b2);
                send_beat(b3);
            end
            begin
                repeat (2) @(posedge clk);
                #1 m_if.tready = 1'b0;
                repeat (3) @(posedge clk);
                #1 m_if.tready = 1'b1;
            end
        join
        idle(6);
        compare_beats("t3");
        check_eq("t3_stall_stability", 512'(stall_viol), 512'(0));
        check_eq("t3_fwd_count", 512'(fwd_count), 512'(2));

        // 4: len 70 declared, 64 bytes delivered
        base_lerr = len_err_pulses;
        b0 = mk_beat(32'h40, mk_user(8'h01, 16'd70), 1'b0);
        b1 = mk_beat(32'h41, 128'h0, 1'b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        send_beat(b0);
        send_beat(b1);
        check_eq("t4_len_err_now", 512'(len_err), 512'(1));
        idle(4);
        compare_beats("t4");
        check_eq("t4_len_err_pulses", 512'(len_err_pulses - base_lerr), 512'(1));
        check_eq("t4_len_err_count", 512'(len_err_count), 512'(1));
        check_eq("t4_fwd_count", 512'(fwd_count), 512'(3));

        // 5: back-to-back single-beat hit / miss / hit, tvalid held high
        base_stall = s_stall_cycles;
        base_lerr  = len_err_pulses;
        b0 = mk_beat(32'h50, mk_user(8'h01, 16'd32), 1'b1);
        b1 = mk_beat(32'h51, mk_user(8'h02, 16'd32), 1'b1);
        b2 = mk_beat(32'h52, mk_user(8'h81, 16'd32), 1'b1);
        exp_q.push_back(b0);
        exp_q.push_back(b2);
        send_beat(b0);
        send_beat(b1);
        send_beat(b2);
        idle(4);
        compare_beats("t5");
        check_eq("t5_s_stalls", 512'(s_stall_cycles - base_stall), 512'(0));
        check_eq("t5_fwd_count", 512'(fwd_count), 512'(5));
        check_eq("t5_drop_count", 512'(drop_count), 512'(2));
        check_eq("t5_len_err_pulses", 512'(len_err_pulses - base_lerr), 512'(0));

        // 6: reset during beat 2 of a 4-beat hit, then a fresh 2-beat packet
        b0 = mk_beat(32'h60, mk_user(8'h01, 16'd128), 1'b0);
        b1 = mk_beat(32'h61, 128'h0, 1'b0);
        exp_q.push_back(b0);
        send_beat(b0);
        s_if.tdata  = b1.d;
        s_if.tstrb  = b1.s;
        s_if.tuser  = b1.u;
        s_if.tlast  = b1.l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_m_tvalid", 512'(m_if.tvalid), 512'(0));
        check_eq("t6_rst_m_tdata", 512'(m_if.tdata), 512'(0));
        check_eq("t6_rst_m_tstrb", 512'(m_if.tstrb), 512'(0));
        check_eq("t6_rst_m_tlast", 512'(m_if.tlast), 512'(0));
        check_eq("t6_rst_s_tready", 512'(s_if.tready), 512'(0));
        check_eq("t6_rst_counts", 512'({fwd_count, drop_count, len_err_count}), 512'(0));
        s_if.tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b2 = mk_beat(32'h70, mk_user(8'h01, 16'd64), 1'b0);
        b3 = mk_beat(32'h71, 128'h0, 1'b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        base_lerr = len_err_pulses;
        send_beat(b2);
        send_beat(b3);
        idle(4);
        compare_beats("t6");
        check_eq("t6_fwd_count", 512'(fwd_count), 512'(1));
        check_eq("t6_drop_count", 512'(drop_count), 512'(0));
        check_eq("t6_len_err_pulses", 512'(len_err_pulses - base_lerr), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/nf10_axis_port_tx_filter.md
# nf10_axis_port_tx_filter

Egress-side AXI-Stream packet gate in front of the 10G interface's slave port (`s_axis_*`). It decodes the 128-bit NetFPGA metadata in `tuser` on each packet's first beat, forwards packets whose destination-port field hits this port's mask, and drops the rest. It also checks that the declared length matches the bytes actually delivered. It is the consumer of the metadata the interface's receive side stamps (length / src_port / dst_port) and keeps per-port statistics.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256, data width for both sides (tstrb width = /8).
- `C_S_AXIS_TUSER_WIDTH`, 128, metadata width for both sides.
- `C_PORT_MASK`, 8'h01, one-hot dst_port bit(s) owned by this interface.
- `axi_aclk`  in  1  single clock.
- `axi_resetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata / tstrb / tuser / tvalid / tlast`  in  256/32/128/1/1  packets from datapath.
- `s_axis_tready`  out  1  upstream ready.
- `m_axis_tdata / tstrb / tuser / tvalid / tlast`  out  256/32/128/1/1  to the 10G interface `s_axis_*`.
- `m_axis_tready`  in  1  downstream ready.
- `fwd_count`  out  32  forwarded packets, saturating.
- `drop_count`  out  32  dropped packets, saturating.
- `len_err_count`  out  16  length-mismatch packets, saturating.
- `len_err`  out  1  one-cycle pulse per mismatched packet.

## Operation
- tuser fields: len = [15:0], src_port = [23:16], dst_port = [31:24]. Fields are valid on the first beat only.
- FSM states: HDR (expect first beat), FWD, DROP. Reset state is HDR.
- HDR, on beat accept: hit = |(dst_port & C_PORT_MASK).
  - If hit: forward the beat and go to FWD.
  - If no hit: discard the beat and go to DROP.
  - A single-beat packet (tlast on the first beat) stays in HDR.
- FWD: forward every beat. On the tlast beat, return to HDR and increment fwd_count.
- DROP: discard every beat. On the tlast beat, return to HDR and increment drop_count.
- The decision uses the current beat's tuser combinationally, so there is no bubble between packets.
- Byte accounting (forwarded packets only):
  - Per-beat count = popcount(tstrb), 0..32.
  - Accumulate into a 16-bit counter that saturates at 16'hFFFF, then clears after tlast.
  - At tlast, compare (accumulated + last-beat count) with len. On mismatch: pulse len_err the next cycle and increment len_err_count. The packet is still forwarded unaltered.
- tstrb is assumed contiguous-from-LSB; non-contiguous patterns are counted by popcount, not validated.
- Forwarded beats pass through the sub-module skid buffer unmodified (data, strb, tuser, last).
- All counters saturate and never wrap.

## Timing
- Reset values: m_axis_tvalid = 0, tdata/tstrb/tuser/tlast = 0, s_axis_tready = 0 while axi_resetn is low, all counters = 0, len_err = 0, FSM in HDR.
- Latency from s accept to m_axis_tvalid is 1 cycle. Throughput is 1 beat/cycle with m_axis_tready held high.
- s_axis_tready:
  - HDR/FWD: equals the skid buffer's not-full.
  - DROP: forced to 1, so drops never stall on downstream backpressure.
  - The HDR decision must not create a combinational path from tuser to s_axis_tready.
- m_axis_tvalid, once high, stays high with stable payload until m_axis_tready is high (AXI-Stream rule).
- fwd_count / drop_count update the cycle after the tlast accept. len_err pulses in that same cycle.
- Reset mid-packet: the buffer is flushed and the FSM returns to HDR. The next accepted beat is treated as a header; a partial packet's tail may be misclassified, which is acceptable.
- Simultaneous counter increment and saturation: the counter holds at its maximum.

## Structure
- Package `nf10_tx_filter_pkg`: tuser field offsets/widths (LEN_LO/HI, SRC_LO/HI, DST_LO/HI), FSM state enum {HDR, FWD, DROP}, and the popcount function.
- One sub-module, `nf10_axis_skid_buffer`: 2-entry register slice with a registered ready, parameterised on data, strb and tuser widths.
- The top level holds the FSM, the byte accumulator and the counters.

## Test plan
- dst_port = 8'h01, len = 64, 2 beats with full tstrb -> identical beats on m 1 cycle later; fwd_count = 1; len_err stays 0.
- dst_port = 8'h04, 3 beats -> no m_axis_tvalid; s_axis_tready = 1 throughout; drop_count = 1.
- Forward packet with m_axis_tready held low for 3 cycles mid-packet -> no beat lost or duplicated, order preserved, payload stable while stalled.
- len = 70, 64 bytes delivered (tstrb 32'hFFFFFFFF twice) -> packet forwarded; len_err pulses once; len_err_count = 1.
- Back-to-back hit/miss/hit single-beat packets with tvalid held high -> beats 1 and 3 forwarded with no bubble; counts fwd = 2, drop = 1.
- Assert axi_resetn low during beat 2 of a 4-beat packet -> all outputs 0 at once; a fresh 2-beat hit packet after release is forwarded correctly and fwd_count = 1.
